// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID->EX pipeline register with MEM/WB operand forwarding
//
// Captures one decoded instruction per valid/ready handshake and presents ALU
// operands from the EX stage. The operands are chosen from the captured
// register data or forwarded from MEM or WB.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   id_*                          decoded instruction from ID, id_ready handshake back
//   mem_rd_*, wb_rd_*             forwarding sources (write enables are valid-qualified)
//   ex_stall, flush               downstream hold and branch redirect
//   ex_valid, oprand_a/b, alu_sel, ex_store_data, ex_rd_*, ex_is_load   EX outputs
//   load_use_stall                one-cycle bubble request for a load-use hazard
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_src_a_pc,
    input  logic              id_src_b_imm,
    input  logic [3:0]        id_alu_sel,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_rd_we,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_rd_we,
    input  logic [DATA_W-1:0] wb_rd_data,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] oprand_a,
    output logic [DATA_W-1:0] oprand_b,
    output logic [3:0]        alu_sel,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_rd_we,
    output logic              ex_is_load,
    output logic              load_use_stall
);

    logic              ex_valid_q,  ex_valid_d;
    logic [DATA_W-1:0] pc_q,        pc_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic [REG_AW-1:0] rs1_addr_q,  rs1_addr_d;
    logic [REG_AW-1:0] rs2_addr_q,  rs2_addr_d;
    logic [DATA_W-1:0] rs1_data_q,  rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q,  rs2_data_d;
    logic              src_a_pc_q,  src_a_pc_d;
    logic              src_b_imm_q, src_b_imm_d;
    logic [3:0]        alu_sel_q,   alu_sel_d;
    logic [REG_AW-1:0] rd_addr_q,   rd_addr_d;
    logic              rd_we_q,     rd_we_d;
    logic              is_load_q,   is_load_d;

    logic [DATA_W-1:0] fwd_rs1;
    logic [DATA_W-1:0] fwd_rs2;
    logic              hazard_rs1;
    logic              hazard_rs2;

    // MEM is the younger producer, so it takes precedence over WB; x0 is never forwarded.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (mem_rd_we && mem_rd_addr == rs1_addr_q && mem_rd_addr != '0)
            fwd_rs1 = mem_rd_data;
        else if (wb_rd_we && wb_rd_addr == rs1_addr_q && wb_rd_addr != '0)
            fwd_rs1 = wb_rd_data;

        fwd_rs2 = rs2_data_q;
        if (mem_rd_we && mem_rd_addr == rs2_addr_q && mem_rd_addr != '0)
            fwd_rs2 = mem_rd_data;
        else if (wb_rd_we && wb_rd_addr == rs2_addr_q && wb_rd_addr != '0)
            fwd_rs2 = wb_rd_data;
    end

    assign hazard_rs1     = id_use_rs1 && (id_rs1_addr == rd_addr_q);
    assign hazard_rs2     = id_use_rs2 && (id_rs2_addr == rd_addr_q);
    assign load_use_stall = ex_valid_q && is_load_q && rd_we_q && (rd_addr_q != '0)
                            && id_valid && (hazard_rs1 || hazard_rs2);
    assign id_ready       = !ex_stall && !load_use_stall && !flush;

    assign ex_valid      = ex_valid_q;
    assign oprand_a      = ex_valid_q ? (src_a_pc_q  ? pc_q  : fwd_rs1) : '0;
    assign oprand_b      = ex_valid_q ? (src_b_imm_q ? imm_q : fwd_rs2) : '0;
    assign ex_store_data = ex_valid_q ? fwd_rs2 : '0;
    assign alu_sel       = alu_sel_q;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_rd_we      = rd_we_q && ex_valid_q;
    assign ex_is_load    = is_load_q && ex_valid_q;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        src_a_pc_d  = src_a_pc_q;
        src_b_imm_d = src_b_imm_q;
        alu_sel_d   = alu_sel_q;
        rd_addr_d   = rd_addr_q;
        rd_we_d     = rd_we_q;
        is_load_d   = is_load_q;

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (ex_stall) begin
            // Soak up forwarded values while held: a producer may leave WB mid-stall.
            rs1_data_d = fwd_rs1;
            rs2_data_d = fwd_rs2;
        end else if (load_use_stall) begin
            ex_valid_d = 1'b0;
        end else if (id_valid) begin
            ex_valid_d  = 1'b1;
            pc_d        = id_pc;
            imm_d       = id_imm;
            rs1_addr_d  = id_rs1_addr;
            rs2_addr_d  = id_rs2_addr;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            src_a_pc_d  = id_src_a_pc;
            src_b_imm_d = id_src_b_imm;
            alu_sel_d   = id_alu_sel;
            rd_addr_d   = id_rd_addr;
            rd_we_d     = id_rd_we;
            is_load_d   = id_is_load;
        end else begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            src_a_pc_q  <= 1'b0;
            src_b_imm_q <= 1'b0;
            alu_sel_q   <= '0;
            rd_addr_q   <= '0;
            rd_we_q     <= 1'b0;
            is_load_q   <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            src_a_pc_q  <= src_a_pc_d;
            src_b_imm_q <= src_b_imm_d;
            alu_sel_q   <= alu_sel_d;
            rd_addr_q   <= rd_addr_d;
            rd_we_q     <= rd_we_d;
            is_load_q   <= is_load_d;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_use_rs1, id_use_rs2, id_src_a_pc, id_src_b_imm, id_rd_we, id_is_load;
    logic [3:0]  id_alu_sel;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic        mem_rd_we, wb_rd_we;
    logic [31:0] mem_rd_data, wb_rd_data;
    logic        ex_stall, flush;
    logic        ex_valid;
    logic [31:0] oprand_a, oprand_b, ex_store_data;
    logic [3:0]  alu_sel;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_we, ex_is_load, load_use_stall;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
        .id_alu_sel(id_alu_sel), .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load),
        .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we), .mem_rd_data(mem_rd_data),
        .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_rd_data(wb_rd_data),
        .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .oprand_a(oprand_a), .oprand_b(oprand_b),
        .alu_sel(alu_sel), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
        .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_valid = 0; id_pc = 0; id_imm = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_src_a_pc = 0; id_src_b_imm = 0;
        id_rd_we = 0; id_is_load = 0; id_alu_sel = 0;
        mem_rd_addr = 0; mem_rd_we = 0; mem_rd_data = 0;
        wb_rd_addr = 0; wb_rd_we = 0; wb_rd_data = 0;
        ex_stall = 0; flush = 0;
    endtask

    task automatic drive_id(input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] r1d, input logic [31:0] r2d,
                            input logic [4:0] r1a, input logic [4:0] r2a, input logic [4:0] rd,
                            input logic u1, input logic u2, input logic sa, input logic sbi,
                            input logic we, input logic ld, input logic [3:0] alu);
        id_valid = 1; id_pc = pc; id_imm = imm; id_rs1_data = r1d; id_rs2_data = r2d;
        id_rs1_addr = r1a; id_rs2_addr = r2a; id_rd_addr = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_src_a_pc = sa; id_src_b_imm = sbi;
        id_rd_we = we; id_is_load = ld; id_alu_sel = alu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        checks++;
        if ({ex_valid, ex_rd_we, ex_is_load, load_use_stall} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {ex_valid, ex_rd_we, ex_is_load, load_use_stall});
        end
        checks++;
        if ({oprand_a, oprand_b, ex_store_data, alu_sel, ex_rd_addr} !== 105'd0) begin
            failures++;
            $display("FAIL reset_data got a=%h b=%h st=%h alu=%h rd=%h exp all 0",
                     oprand_a, oprand_b, ex_store_data, alu_sel, ex_rd_addr);
        end
        // reset while a live instruction sits in EX
        drive_id(32'h40, 32'h4, 32'h1234, 32'h5678, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0, 1, 0, 4'h3);
        tick();
        id_valid = 0;
        checks++;
        if ({ex_valid, ex_rd_we} !== 2'b11) begin
            failures++;
            $display("FAIL midop_live got=%b exp=11", {ex_valid, ex_rd_we});
        end
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++;
        if ({ex_valid, ex_rd_we} !== 2'b00 || oprand_a !== 32'h0 || alu_sel !== 4'h0) begin
            failures++;
            $display("FAIL midop_reset got v=%b we=%b a=%h alu=%h exp 0", ex_valid, ex_rd_we, oprand_a, alu_sel);
        end
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        drive_id(0, 0, 32'h33, 0, 5'd5, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0, 4'h2);
        tick();
        id_valid = 0;
        mem_rd_we = 1; mem_rd_addr = 5; mem_rd_data = 32'h11;
        wb_rd_we = 1;  wb_rd_addr = 5;  wb_rd_data = 32'h22;
        #1;
        checks++;
        if (oprand_a !== 32'h11) begin
            failures++;
            $display("FAIL fwd_mem_over_wb got=%h exp=%h", oprand_a, 32'h11);
        end
        mem_rd_we = 0;
        #1;
        checks++;
        if (oprand_a !== 32'h22) begin
            failures++;
            $display("FAIL fwd_wb got=%h exp=%h", oprand_a, 32'h22);
        end
        mem_rd_we = 1;
        #1;
        checks++;
        if (oprand_a !== 32'h11) begin
            failures++;
            $display("FAIL fwd_mem_again got=%h exp=%h", oprand_a, 32'h11);
        end
        mem_rd_we = 0; wb_rd_we = 0;
        #1;
        checks++;
        if (oprand_a !== 32'h33) begin
            failures++;
            $display("FAIL fwd_none got=%h exp=%h", oprand_a, 32'h33);
        end
        drive_id(0, 0, 32'h77, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0, 4'h2);
        tick();
        id_valid = 0;
        mem_rd_we = 1; mem_rd_addr = 0; mem_rd_data = 32'h11;
        wb_rd_we = 1;  wb_rd_addr = 0;  wb_rd_data = 32'h22;
        #1;
        checks++;
        if (oprand_a !== 32'h77) begin
            failures++;
            $display("FAIL fwd_x0 got=%h exp=%h", oprand_a, 32'h77);
        end
        mem_rd_we = 0; wb_rd_we = 0;
    endtask

    task automatic test_load_use();
        exp_t e;
        clear_inputs();
        tick();
        // lw x6, 8(x2)
        drive_id(0, 32'h8, 32'h40, 0, 5'd2, 5'd0, 5'd6, 1, 0, 0, 1, 1, 1, 4'h0);
        exp_q.push_back('{a: 32'h40, b: 32'h8, st: 32'h0, alu: 4'h0, rd: 5'd6, we: 1'b1});
        tick();
        // add x7, x6, x1
        drive_id(0, 0, 32'hDEAD, 32'h10, 5'd6, 5'd1, 5'd7, 1, 1, 0, 0, 1, 0, 4'h0);
        #1;
        checks++;
        if (!ex_valid || exp_q.size() == 0) begin
            failures++;
            $display("FAIL lu_load_in_ex got valid=%b queued=%0d exp valid=1", ex_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({oprand_a, oprand_b, ex_store_data, alu_sel, ex_rd_addr, ex_rd_we} !==
                {e.a, e.b, e.st, e.alu, e.rd, e.we} || ex_is_load !== 1'b1) begin
                failures++;
                $display("FAIL lu_load_in_ex got a=%h b=%h rd=%0d ld=%b exp a=%h b=%h rd=%0d ld=1",
                         oprand_a, oprand_b, ex_rd_addr, ex_is_load, e.a, e.b, e.rd);
            end
        end
        checks++;
        if ({load_use_stall, id_ready} !== 2'b10) begin
            failures++;
            $display("FAIL lu_detect got stall,ready=%b exp=10", {load_use_stall, id_ready});
        end
        exp_q.push_back('{a: 32'hCAFE, b: 32'h10, st: 32'h10, alu: 4'h0, rd: 5'd7, we: 1'b1});
        tick();
        checks++;
        if ({ex_valid, load_use_stall, id_ready} !== 3'b001) begin
            failures++;
            $display("FAIL lu_bubble got valid,stall,ready=%b exp=001", {ex_valid, load_use_stall, id_ready});
        end
        tick();
        id_valid = 0;
        wb_rd_we = 1; wb_rd_addr = 6; wb_rd_data = 32'hCAFE;
        #1;
        checks++;
        if (!ex_valid || exp_q.size() == 0) begin
            failures++;
            $display("FAIL lu_consumer got valid=%b queued=%0d exp valid=1", ex_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({oprand_a, oprand_b, ex_store_data, alu_sel, ex_rd_addr, ex_rd_we} !==
                {e.a, e.b, e.st, e.alu, e.rd, e.we}) begin
                failures++;
                $display("FAIL lu_consumer got a=%h b=%h st=%h rd=%0d exp a=%h b=%h st=%h rd=%0d",
                         oprand_a, oprand_b, ex_store_data, ex_rd_addr, e.a, e.b, e.st, e.rd);
            end
        end
        wb_rd_we = 0;
    endtask

    task automatic test_stall();
        clear_inputs();
        drive_id(0, 0, 32'h1, 0, 5'd9, 5'd0, 5'd10, 1, 0, 0, 0, 1, 0, 4'h1);
        tick();
        ex_stall = 1;
        drive_id(0, 0, 32'h2, 0, 5'd0, 5'd0, 5'd11, 0, 0, 0, 0, 1, 0, 4'h5);
        wb_rd_we = 1; wb_rd_addr = 9; wb_rd_data = 32'hABCD;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++;
            if (oprand_a !== 32'hABCD || ex_valid !== 1'b1 || ex_rd_addr !== 5'd10 || id_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_cycle%0d got a=%h v=%b rd=%0d rdy=%b exp a=abcd v=1 rd=10 rdy=0",
                         c, oprand_a, ex_valid, ex_rd_addr, id_ready);
            end
            tick();
            wb_rd_we = 0;
        end
        ex_stall = 0;
        #1;
        checks++;
        if (oprand_a !== 32'hABCD || ex_rd_addr !== 5'd10 || id_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got a=%h rd=%0d rdy=%b exp a=abcd rd=10 rdy=1", oprand_a, ex_rd_addr, id_ready);
        end
        tick();
        id_valid = 0;
        checks++;
        if (ex_valid !== 1'b1 || ex_rd_addr !== 5'd11 || alu_sel !== 4'h5) begin
            failures++;
            $display("FAIL stall_next got v=%b rd=%0d alu=%h exp v=1 rd=11 alu=5", ex_valid, ex_rd_addr, alu_sel);
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        drive_id(0, 0, 32'h3, 0, 5'd1, 5'd0, 5'd4, 1, 0, 0, 0, 1, 0, 4'h6);
        tick();
        ex_stall = 1; flush = 1;
        drive_id(0, 0, 32'h9, 0, 5'd1, 5'd0, 5'd8, 1, 0, 0, 0, 1, 0, 4'h7);
        #1;
        checks++;
        if (id_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready got=%b exp=0", id_ready);
        end
        tick();
        ex_stall = 0; flush = 0; id_valid = 0;
        #1;
        checks++;
        if ({ex_valid, ex_rd_we} !== 2'b00 || oprand_a !== 32'h0 || ex_rd_addr === 5'd8) begin
            failures++;
            $display("FAIL flush_kill got v=%b we=%b a=%h rd=%0d exp v=0 we=0 a=0 rd!=8",
                     ex_valid, ex_rd_we, oprand_a, ex_rd_addr);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_dropped got v=%b exp=0", ex_valid);
        end
    endtask

    task automatic test_sources();
        exp_t e;
        clear_inputs();
        drive_id(32'h100, 32'hFFFFF800, 32'h44, 32'h99, 5'd4, 5'd3, 5'd12, 1, 1, 1, 1, 1, 0, 4'h0);
        exp_q.push_back('{a: 32'h100, b: 32'hFFFFF800, st: 32'h55, alu: 4'h0, rd: 5'd12, we: 1'b1});
        tick();
        id_valid = 0;
        mem_rd_we = 1; mem_rd_addr = 3; mem_rd_data = 32'h55;
        #1;
        checks++;
        if (!ex_valid || exp_q.size() == 0) begin
            failures++;
            $display("FAIL sources got valid=%b queued=%0d exp valid=1", ex_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({oprand_a, oprand_b, ex_store_data, alu_sel, ex_rd_addr, ex_rd_we} !==
                {e.a, e.b, e.st, e.alu, e.rd, e.we}) begin
                failures++;
                $display("FAIL sources got a=%h b=%h st=%h exp a=%h b=%h st=%h",
                         oprand_a, oprand_b, ex_store_data, e.a, e.b, e.st);
            end
        end
        mem_rd_we = 0;
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] pc, imm, r1d, r2d;
        logic        sa, sbi, we, gap;
        logic [3:0]  alu;
        logic [4:0]  rd;
        clear_inputs();
        for (int i = 0; i < 20; i++) begin
            gap = ($urandom_range(0, 3) == 0);
            if (gap) begin
                id_valid = 0;
            end else begin
                pc = $urandom; imm = $urandom; r1d = $urandom; r2d = $urandom;
                sa = 1'($urandom_range(0, 1)); sbi = 1'($urandom_range(0, 1));
                we = 1'($urandom_range(0, 1)); alu = 4'($urandom_range(0, 15));
                rd = 5'($urandom_range(0, 31));
                drive_id(pc, imm, r1d, r2d, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rd,
                         1, 1, sa, sbi, we, 0, alu);
                exp_q.push_back('{a: sa ? pc : r1d, b: sbi ? imm : r2d, st: r2d, alu: alu, rd: rd, we: we});
            end
            checks++;
            if (id_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d] got=%b exp=1", i, id_ready);
            end
            tick();
            checks++;
            if (gap) begin
                if (ex_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_gap[%0d] got v=%b exp=0", i, ex_valid);
                end
            end else if (!ex_valid || exp_q.size() == 0) begin
                failures++;
                $display("FAIL b2b_issue[%0d] got v=%b queued=%0d exp v=1", i, ex_valid, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                if ({oprand_a, oprand_b, ex_store_data, alu_sel, ex_rd_addr, ex_rd_we} !==
                    {e.a, e.b, e.st, e.alu, e.rd, e.we}) begin
                    failures++;
                    $display("FAIL b2b_issue[%0d] got a=%h b=%h st=%h alu=%h rd=%0d we=%b exp a=%h b=%h st=%h alu=%h rd=%0d we=%b",
                             i, oprand_a, oprand_b, ex_store_data, alu_sel, ex_rd_addr, ex_rd_we,
                             e.a, e.b, e.st, e.alu, e.rd, e.we);
                end
            end
        end
        id_valid = 0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_stall();
        test_flush();
        test_sources();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
